seq_detect_ctrl: RTL

- Run-time configurable controller for serial bit-pattern detection. Holds a programmable pattern and length, and arms/disarms scanning of a valid-qualified serial stream.
- Reports every match, overlap included, through a valid/ready event port carrying a match index and a running count.
- Sits between a host/config master and the serial input. It generalises the fixed 10011 Moore detector into a sequenced, programmable resource.

---
 rtl/seq_ctrl_pkg.sv | 23 ++
 rtl/seq_detect_ctrl_if.sv | 32 +++
 rtl/seq_match_core.sv | 57 +++++
 rtl/seq_detect_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
package seq_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'b0001_0011;
  localparam int         DEFAULT_LEN     = 5;

  // A zero length would match nothing meaningful, so it is treated as one bit.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host/stream/event bundle for seq_detect_ctrl; master drives config, stream and ready.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               start;
  logic               stop;
  logic               i;
  logic               i_valid;
  // Event port: match_valid/match_idx stay stable until an edge with
  // match_valid && match_ready retires the event; ready may depend on valid.
  logic               match_valid;
  logic               match_ready;
  logic [CNT_W-1:0]   match_idx;
  logic [CNT_W-1:0]   match_cnt;
  logic               overrun;
  logic               busy;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, start, stop, i, i_valid, match_ready,
    input  match_valid, match_idx, match_cnt, overrun, busy
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, start, stop, i, i_valid, match_ready,
    output match_valid, match_idx, match_cnt, overrun, busy
  );
endinterface

// File: rtl/seq_match_core.sv
// Shift history, saturating bits-seen count and masked compare against the pattern.
module seq_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               match_next_o
);

  localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [MAX_LEN-1:0] mask;

  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    if (clear_i) begin
      hist_d = '0;
      seen_d = '0;
    end else if (shift_i) begin
      hist_d = {hist_q[MAX_LEN-2:0], bit_i};
      if (seen_q != SEEN_MAX) begin
        seen_d = seen_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int b = 0; b < MAX_LEN; b++) begin
      mask[b] = (b < int'(len_i));
    end
  end

  // Judged on the post-shift history so the event lands on the same edge.
  assign match_next_o = shift_i && (seen_d >= len_i) &&
                        (((hist_d ^ pattern_i) & mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      seen_q <= '0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with armed scanning and a valid/ready match event port.
// Optional: define SEQ_AUTO_STOP_EN for one-shot mode (return to IDLE on the matching edge).
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_detect_ctrl_if.slave   ctrl_if,
  output state_e             state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   midx_q, midx_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic               mv_q, mv_d;
  logic               ovr_q, ovr_d;

  logic start_go, stop_now, shift, retire, match_next;

  assign start_go = (state_q == IDLE) && ctrl_if.start && !ctrl_if.stop;
  assign shift    = (state_q == SCAN) && ctrl_if.i_valid;
  assign retire   = mv_q && ctrl_if.match_ready;

`ifdef SEQ_AUTO_STOP_EN
  assign stop_now = (state_q == SCAN) && (ctrl_if.stop || match_next);
`else
  assign stop_now = (state_q == SCAN) && ctrl_if.stop;
`endif

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_go),
    .shift_i      (shift),
    .bit_i        (ctrl_if.i),
    .pattern_i    (pattern_q),
    .len_i        (len_q),
    .match_next_o (match_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_go) state_q <= SCAN;
        SCAN:    if (stop_now) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    midx_d    = midx_q;
    mcnt_d    = mcnt_q;
    mv_d      = mv_q;
    ovr_d     = ovr_q;
    if ((state_q == IDLE) && ctrl_if.cfg_we) begin
      pattern_d = ctrl_if.cfg_pattern;
      len_d     = LEN_W'(clamp_len(int'(ctrl_if.cfg_len), MAX_LEN));
    end
    // A pending event deliberately survives START; only counters restart.
    if (start_go) begin
      idx_d  = '0;
      mcnt_d = '0;
      ovr_d  = 1'b0;
    end
    if (shift) begin
      idx_d = idx_q + CNT_ONE;
    end
    if (retire) begin
      mv_d = 1'b0;
    end
    if (match_next) begin
      if (!mv_q || retire) begin
        mv_d   = 1'b1;
        midx_d = idx_q;
      end else begin
        ovr_d  = 1'b1;
      end
      if (mcnt_q != '1) begin
        mcnt_d = mcnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= MAX_LEN'(DEFAULT_PATTERN);
      len_q     <= LEN_W'(DEFAULT_LEN);
      idx_q     <= '0;
      midx_q    <= '0;
      mcnt_q    <= '0;
      mv_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      midx_q    <= midx_d;
      mcnt_q    <= mcnt_d;
      mv_q      <= mv_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ctrl_if.match_valid = mv_q;
  assign ctrl_if.match_idx   = midx_q;
  assign ctrl_if.match_cnt   = mcnt_q;
  assign ctrl_if.overrun     = ovr_q;
  assign ctrl_if.busy        = (state_q == SCAN);
  assign state_o             = state_q;

endmodule
